// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Purpose:
//   Pipelined bitwise logic unit. An operation is evaluated at the moment it
//   is accepted, and its result is written into a 2-entry in-order output
//   buffer. Operands are never stored. The buffer drains through a
//   valid/ready handshake.
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      asynchronous assert, active-low reset
//   in_valid   in   1      upstream offers an operation
//   in_ready   out  1      registered; high while buffer occupancy < 2
//   a, b       in   WIDTH  operands
//   op         in   3      0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                          6 NOT A, 7 PASS A
//   out_valid  out  1      result present at buffer head
//   out_ready  in   1      downstream consumes the head
//   y          out  WIDTH  head result, 0 when the buffer is empty
//   y_all      out  1      AND-reduction of y
//   y_any      out  1      OR-reduction of y
//   op_count   out  16     pop counter, wraps; only with LOGIC_UNIT_STATS_EN
//
// Configuration:
//   `define LOGIC_UNIT_STATS_EN adds the op_count port and its counter.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_all,
   output logic             y_any
`ifdef LOGIC_UNIT_STATS_EN
   ,
   output logic [15:0]      op_count
`endif
);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q, count_d;
   logic             in_ready_q;
   logic [WIDTH-1:0] result_d;
   logic             push;
   logic             pop;

   assign push      = in_valid && in_ready_q;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign in_ready  = in_ready_q;

   // Result is formed from the live operands; only the result is buffered.
   // NOTE: every always_comb output gets a default first so no path through
   // the block leaves it unassigned, which would infer a latch.
   always_comb begin
      result_d = '0;
      case (op_e'(op))
         OP_AND:  result_d = a & b;
         OP_OR:   result_d = a | b;
         OP_XOR:  result_d = a ^ b;
         OP_NAND: result_d = ~(a & b);
         OP_NOR:  result_d = ~(a | b);
         OP_XNOR: result_d = ~(a ^ b);
         OP_NOTA: result_d = ~a;
         OP_PASS: result_d = a;
         default: result_d = '0;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // in_ready is derived from next occupancy and registered, so it has no
   // combinational dependence on in_valid or out_ready. It is held low in
   // reset and rises on the first edge after release.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d != 2'd2);
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // NOTE: the data entries are deliberately not reset; occupancy gates every
   // read, so stale contents can never reach y.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= result_d;
   end

   assign y     = out_valid ? mem_q[rd_ptr_q] : '0;
   assign y_all = out_valid && (&mem_q[rd_ptr_q]);
   assign y_any = out_valid && (|mem_q[rd_ptr_q]);

`ifdef LOGIC_UNIT_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   op_count_q <= 16'd0;
      else if (pop) op_count_q <= op_count_q + 16'd1;
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Scoreboard bench for logic_unit_pipe (WIDTH=8). Stimulus pushes the
// hand-computed result of each accepted op into a queue; a monitor on the
// falling edge pops and compares whenever the DUT pops a result.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         y_all, y_any;
`ifdef LOGIC_UNIT_STATS_EN
   logic [15:0]  op_count;
`endif

   int tests  = 0;
   int failed = 0;
   logic [W-1:0] exp_q [$];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_all     (y_all),
      .y_any     (y_any)
`ifdef LOGIC_UNIT_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every popped head against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", {56'd0, y}, 64'hDEAD);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("y",     {56'd0, y}, {56'd0, e});
            check("y_all", {63'd0, y_all}, {63'd0, &e});
            check("y_any", {63'd0, y_any}, {63'd0, |e});
         end
      end
   end

   // Offer one op until accepted (bounded); expected result queued at acceptance.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input logic [W-1:0] ey);
      bit ok = 0;
      in_valid = 1'b1; a = ia; b = ib; op = iop;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ey);
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
      end
      check("drain", {63'd0, ok}, 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   logic [W-1:0] exp31 [8];

   initial begin
      exp31[0] = 8'h30; exp31[1] = 8'hFC; exp31[2] = 8'hCC; exp31[3] = 8'hCF;
      exp31[4] = 8'h03; exp31[5] = 8'h33; exp31[6] = 8'h0F; exp31[7] = 8'hF0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;

      // Reset state
      #2;
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_y",         {56'd0, y},         64'd0);
      check("rst_y_all",     {63'd0, y_all},     64'd0);
      check("rst_y_any",     {63'd0, y_any},     64'd0);
      repeat (2) @(posedge clk);
      #1 check("rst_hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", {63'd0, in_ready}, 64'd1);
      check("empty_y", {56'd0, y}, 64'd0);

      // All eight ops back-to-back, each visible one cycle after transfer
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(8'hF0, 8'h3C, 3'(i), exp31[i]);
         #2;
         check("lat_valid", {63'd0, out_valid}, 64'd1);
         check("lat_y", {56'd0, y}, {56'd0, exp31[i]});
      end
      drain();

      // Reduction boundaries
      issue(8'hFF, 8'hFF, 3'd0, 8'hFF);
      issue(8'h00, 8'h00, 3'd1, 8'h00);
      drain();

      // Backpressure: two fill the buffer, third held until drained
      out_ready = 1'b0;
      issue(8'hAA, 8'h55, 3'd1, 8'hFF);
      issue(8'hAA, 8'h0F, 3'd0, 8'h0A);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_valid", {63'd0, out_valid}, 64'd1);
      in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 3'd2;
      repeat (2) begin
         @(negedge clk);
         check("full_hold", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      check("full_no_push", {32'd0, exp_q.size()}, 64'd2);
      out_ready = 1'b1;
      issue(8'h12, 8'h34, 3'd2, 8'h26);
      drain();

      // Simultaneous push and pop at occupancy 1
      out_ready = 1'b0;
      issue(8'h0F, 8'h00, 3'd7, 8'h0F);
      out_ready = 1'b1;
      issue(8'h0F, 8'hF0, 3'd4, 8'h00);
      #2;
      check("pp_valid", {63'd0, out_valid}, 64'd1);
      check("pp_ready", {63'd0, in_ready}, 64'd1);
      check("pp_y", {56'd0, y}, 64'h00);
      drain();

      // Asynchronous reset with the buffer full
      out_ready = 1'b0;
      issue(8'hC3, 8'h00, 3'd6, 8'h3C);
      issue(8'hC3, 8'h81, 3'd5, 8'hBD);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, out_valid}, 64'd0);
      check("arst_ready", {63'd0, in_ready}, 64'd0);
      check("arst_y", {56'd0, y}, 64'd0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_rel_ready", {63'd0, in_ready}, 64'd1);
      check("arst_empty", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;
      issue(8'h5A, 8'hFF, 3'd2, 8'hA5);
      drain();

`ifdef LOGIC_UNIT_STATS_EN
      // 65537 pops wrap the counter to 1
      do_reset();
      check("cnt_reset", {48'd0, op_count}, 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 65537; i++) issue(8'h01, 8'h01, 3'd0, 8'h01);
      drain();
      check("cnt_wrap", {48'd0, op_count}, 64'd1);
`endif

      check("sb_empty", {32'd0, exp_q.size()}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
